// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor. Processes one bit per clock, LSB first,
// through a single full adder. It holds the last completed result and
// flags until the next operation finishes.
`timescale 1ns/1ps

module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             v,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fin;
  logic             armed;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_msb;
  logic             accept;
  logic             step;
  logic             fa_sum;
  logic             fa_carry;

  // One-bit full adder: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // The operand shift registers hold the bit that is currently being
  // processed in position 0. The carry flop provides the carry-in.
  // The armed flag blocks start on the edge that releases reset.
  always_comb begin
    accept              = start && armed && (state != CALC);
    step                = (state == CALC) && !fin;
    {fa_carry, fa_sum}  = full_add(a_sr[0], b_sr[0], carry);
  end

  // Control FSM and registered outputs. The bits are processed during
  // WIDTH CALC cycles. A final CALC cycle then publishes the result, so
  // partial sums never reach the result output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      v      <= 1'b0;
      zero   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      fin    <= 1'b0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            carry <= mode;
            cnt   <= '0;
            fin   <= 1'b0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          if (!fin) begin
            carry <= fa_carry;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              fin <= 1'b1;
            end
          end else begin
            result <= sum_sr;
            cout   <= carry;
            v      <= carry_msb ^ carry;
            zero   <= ~|sum_sr;
            done   <= 1'b1;
            busy   <= 1'b0;
            fin    <= 1'b0;
            cnt    <= '0;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand and sum shift registers. The operands are captured only on
  // an accepted start, so changes during CALC have no effect. The carry
  // into the MSB is kept for the overflow flag.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= a;
      b_sr <= b ^ {WIDTH{mode}};
    end else if (step) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
      if (cnt == LAST_BIT) begin
        carry_msb <= carry;
      end
    end
  end

endmodule
